// File: rtl/wb_irq_ctrl.sv
// Wishbone-attached interrupt controller: per-channel edge/level detection,
// polarity, enable masking and a lowest-index-first ID register.
module wb_irq_ctrl #(
  parameter int unsigned NUM_IRQ    = 32,
  parameter logic [31:0] ENABLE_RST = 32'h0
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [4:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               wb_rty_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               irq_o
);

  typedef enum logic [2:0] {
    REG_RAW      = 3'd0,
    REG_PENDING  = 3'd1,
    REG_ENABLE   = 3'd2,
    REG_MODE     = 3'd3,
    REG_POLARITY = 3'd4,
    REG_ID       = 3'd5
  } reg_e;

  logic [NUM_IRQ-1:0] pending, enable, mode, polarity, prev;
  logic [NUM_IRQ-1:0] pending_d, enable_d, mode_d, polarity_d;
  logic [NUM_IRQ-1:0] act, rise, w1c, changed, active;
  logic [NUM_IRQ-1:0] wr_mask, wr_bits;
  logic [31:0]        byte_mask, rdata, id_val;
  logic [4:0]         id_idx;
  logic               req, wr;
  reg_e               reg_sel;

  // Byte-offset bits carry no meaning; registers are word-aligned.
  logic unused_adr;
  assign unused_adr = &{1'b0, wb_adr_i[1:0]};

  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;

  // Suppressing a request while ack is high yields one ack per two cycles
  // under back-to-back strobes.
  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr      = req & wb_we_i;
  assign reg_sel = reg_e'(wb_adr_i[4:2]);

  assign byte_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                      {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wr_mask   = byte_mask[NUM_IRQ-1:0];
  assign wr_bits   = wb_dat_i[NUM_IRQ-1:0] & wr_mask;

  assign act    = irq_i ^ polarity;
  assign rise   = act & ~prev;
  assign active = pending & enable;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a value unassigned, which would infer a latch.
    enable_d   = enable;
    mode_d     = mode;
    polarity_d = polarity;
    w1c        = '0;
    if (wr) begin
      case (reg_sel)
        REG_PENDING:  w1c        = wr_bits;
        REG_ENABLE:   enable_d   = (enable   & ~wr_mask) | wr_bits;
        REG_MODE:     mode_d     = (mode     & ~wr_mask) | wr_bits;
        REG_POLARITY: polarity_d = (polarity & ~wr_mask) | wr_bits;
        default: ;
      endcase
    end
    changed = (mode_d ^ mode) | (polarity_d ^ polarity);
    // Edge bits: clear first, then set, so a coincident new edge survives.
    // Level bits track the registered activity and ignore W1C.
    pending_d = ((mode & ((pending & ~w1c) | rise)) | (~mode & act)) & ~changed;
  end

  always_comb begin
    id_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) id_idx = 5'(i);
    end
    id_val = {|active, 26'd0, id_idx};
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_RAW:      rdata = 32'(act);
      REG_PENDING:  rdata = 32'(pending);
      REG_ENABLE:   rdata = 32'(enable);
      REG_MODE:     rdata = 32'(mode);
      REG_POLARITY: rdata = 32'(polarity);
      REG_ID:       rdata = id_val;
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (wb_rst_i) begin
      pending  <= '0;
      enable   <= ENABLE_RST[NUM_IRQ-1:0];
      mode     <= '0;
      polarity <= '0;
      prev     <= '0;
      irq_o    <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      pending  <= pending_d;
      enable   <= enable_d;
      mode     <= mode_d;
      polarity <= polarity_d;
      prev     <= act;
      irq_o    <= |active;
      wb_ack_o <= req;
      wb_dat_o <= req ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Directed bench for wb_irq_ctrl with 12 channels and a reset ENABLE value
// wider than the channel count, so truncation is visible.
module tb_wb_irq_ctrl;

  localparam int unsigned N      = 12;
  localparam logic [31:0] EN_RST = 32'hFFFF_F0A5;

  localparam logic [4:0] A_RAW  = 5'h00;
  localparam logic [4:0] A_PEND = 5'h04;
  localparam logic [4:0] A_EN   = 5'h08;
  localparam logic [4:0] A_MODE = 5'h0C;
  localparam logic [4:0] A_POL  = 5'h10;
  localparam logic [4:0] A_ID   = 5'h14;
  localparam logic [4:0] A_GAP  = 5'h1C;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    adr;
  logic [31:0]   dat_i;
  logic [3:0]    sel;
  logic          we, cyc, stb;
  logic [31:0]   dat_o;
  logic          ack, err, rty;
  logic [N-1:0]  irq;
  logic          irq_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_irq_ctrl #(.NUM_IRQ(N), .ENABLE_RST(EN_RST)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wb_adr_i(adr),
    .wb_dat_i(dat_i),
    .wb_sel_i(sel),
    .wb_we_i (we),
    .wb_cyc_i(cyc),
    .wb_stb_i(stb),
    .wb_dat_o(dat_o),
    .wb_ack_o(ack),
    .wb_err_o(err),
    .wb_rty_o(rty),
    .irq_i   (irq),
    .irq_o   (irq_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // Each bus task starts and ends 1 time unit after a rising edge.
  task automatic wb_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    adr = a; dat_i = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("write_ack", 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_read(input logic [4:0] a, output logic [31:0] d);
    adr = a; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("read_ack", 32'(ack), 32'd1);
    d = dat_o;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic expect_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(a, d);
    check(tag, d, exp);
  endtask

  initial begin
    rst = 1'b1; adr = '0; dat_i = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    irq = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   32'(ack),   32'd0);
    check("rst_irq_o", 32'(irq_o), 32'd0);
    check("rst_dat_o", dat_o,      32'd0);
    check("err_rty",   {30'd0, err, rty}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    expect_reg("rst_enable",   A_EN,   32'h0000_00A5);
    expect_reg("rst_pending",  A_PEND, 32'h0);
    expect_reg("rst_mode",     A_MODE, 32'h0);
    expect_reg("rst_polarity", A_POL,  32'h0);

    // Edge channel 3
    wb_write(A_MODE, 32'h8, 4'hF);
    wb_write(A_EN,   32'h8, 4'hF);
    irq = 12'h008;
    @(posedge clk); #1;
    irq = '0;
    check("edge_irq_o_lag", 32'(irq_o), 32'd0);
    @(posedge clk); #1;
    check("edge_irq_o", 32'(irq_o), 32'd1);
    expect_reg("edge_pending", A_PEND, 32'h8);
    expect_reg("edge_id",      A_ID,   32'h8000_0003);
    wb_write(A_PEND, 32'h8, 4'hF);
    check("edge_w1c_irq_o", 32'(irq_o), 32'd0);
    expect_reg("edge_w1c_pending", A_PEND, 32'h0);

    // Level channel 1, active-low
    wb_write(A_MODE, 32'h0, 4'hF);
    wb_write(A_POL,  32'h2, 4'hF);
    wb_write(A_EN,   32'h2, 4'hF);
    expect_reg("level_raw",     A_RAW,  32'h2);
    expect_reg("level_pending", A_PEND, 32'h2);
    check("level_irq_o", 32'(irq_o), 32'd1);
    wb_write(A_PEND, 32'h2, 4'hF);
    expect_reg("level_w1c_ignored", A_PEND, 32'h2);
    irq = 12'h002;
    @(posedge clk); #1;
    expect_reg("level_deassert", A_PEND, 32'h0);
    check("level_irq_o_low", 32'(irq_o), 32'd0);
    irq = '0;
    wb_write(A_POL, 32'h0, 4'hF);
    expect_reg("pol_restore_pending", A_PEND, 32'h0);

    // Priority: edges on 5 and 9 together
    wb_write(A_MODE, 32'h220, 4'hF);
    wb_write(A_EN,   32'h220, 4'hF);
    irq = 12'h220;
    @(posedge clk); #1;
    irq = '0;
    expect_reg("prio_id_5", A_ID, 32'h8000_0005);
    wb_write(A_PEND, 32'h20, 4'hF);
    expect_reg("prio_id_9",   A_ID,   32'h8000_0009);
    expect_reg("prio_pending", A_PEND, 32'h200);

    // Masking keeps the pending bit
    wb_write(A_EN, 32'h0, 4'hF);
    check("disable_irq_o", 32'(irq_o), 32'd0);
    expect_reg("disable_keeps_pending", A_PEND, 32'h200);
    expect_reg("disable_id", A_ID, 32'h0);
    wb_write(A_EN, 32'h200, 4'hF);
    check("reenable_irq_o", 32'(irq_o), 32'd1);
    wb_write(A_PEND, 32'h200, 4'hF);
    check("clear_irq_o", 32'(irq_o), 32'd0);
    expect_reg("clear_id", A_ID, 32'h0);

    // Set beats clear on channel 0
    wb_write(A_MODE, 32'h1, 4'hF);
    irq = 12'h001;
    wb_write(A_PEND, 32'h1, 4'hF);
    irq = '0;
    expect_reg("set_wins", A_PEND, 32'h1);
    wb_write(A_PEND, 32'h1, 4'hF);
    expect_reg("w1c_edge", A_PEND, 32'h0);

    // Byte lanes and bounds
    wb_write(A_EN, 32'h0, 4'hF);
    wb_write(A_EN, 32'hFFFF_FFFF, 4'b0001);
    expect_reg("sel_lane0", A_EN, 32'h0000_00FF);
    wb_write(A_EN, 32'hFFFF_FFFF, 4'hF);
    expect_reg("sel_all_trunc", A_EN, 32'h0000_0FFF);
    wb_write(A_EN, 32'h0, 4'hF);
    wb_write(A_EN, 32'hFFFF_FFFF, 4'b0010);
    expect_reg("sel_lane1", A_EN, 32'h0000_0F00);
    expect_reg("gap_read", A_GAP, 32'h0);
    wb_write(A_GAP, 32'hFFFF_FFFF, 4'hF);
    expect_reg("gap_write_ignored", A_EN, 32'h0000_0F00);

    // Back-to-back strobes: ack every other cycle
    adr = A_EN; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1; check("b2b_ack0", 32'(ack), 32'd1);
    @(posedge clk); #1; check("b2b_ack1", 32'(ack), 32'd0);
    @(posedge clk); #1; check("b2b_ack2", 32'(ack), 32'd1);
    @(posedge clk); #1; check("b2b_ack3", 32'(ack), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    // Reset aborts a write that starts in the same cycle
    wb_write(A_POL, 32'h4, 4'hF);
    expect_reg("pre_rst_pending", A_PEND, 32'h4);
    rst = 1'b1;
    adr = A_EN; dat_i = 32'h123; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("rst_abort_ack",   32'(ack),   32'd0);
    check("rst_abort_irq_o", 32'(irq_o), 32'd0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("rst_abort_no_late_ack", 32'(ack), 32'd0);
    expect_reg("rst_abort_enable",   A_EN,   32'h0000_00A5);
    expect_reg("rst_abort_mode",     A_MODE, 32'h0);
    expect_reg("rst_abort_polarity", A_POL,  32'h0);
    expect_reg("rst_abort_pending",  A_PEND, 32'h0);
    expect_reg("rst_abort_id",       A_ID,   32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_irq_ctrl.md
WB_IRQ_CTRL -- requirements
Module: wb_irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 32, SHALL set the number of interrupt channels; legal range is 1..32.
REQ-002 Parameter ENABLE_RST, default 32'h0, SHALL set the ENABLE register value loaded on reset.
REQ-003 Ports, in order:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  synchronous active-high reset
wb_adr_i  in  5  byte address; bits [4:2] decode the register
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte enables
wb_we_i  in  1  write strobe
wb_cyc_i  in  1  cycle valid
wb_stb_i  in  1  strobe
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
wb_err_o  out  1  tied 0
wb_rty_o  out  1  tied 0
irq_i  in  NUM_IRQ  interrupt sources, synchronous to wb_clk_i
irq_o  out  1  aggregated interrupt to CPU
REQ-004 Clock is wb_clk_i only; reset is wb_rst_i, synchronous and active-high.

Function
REQ-005 Register map (offset: name, access) SHALL be: 0x00 RAW (RO, irq_i after polarity), 0x04 PENDING (R, W1C), 0x08 ENABLE (RW), 0x0C MODE (RW; 1=edge, 0=level), 0x10 POLARITY (RW; 1=active-low/falling), 0x14 ID (RO).
REQ-006 Unmapped offsets SHALL read 0, ignore writes, and still ack.
REQ-007 Register bits at or above NUM_IRQ SHALL read 0 and ignore writes.
REQ-008 Writes SHALL honour wb_sel_i per byte lane.
REQ-009 Ack handshake:
- wb_ack_o SHALL assert one cycle after wb_cyc_i & wb_stb_i & !wb_ack_o.
- wb_ack_o SHALL stay high exactly one cycle.
- Back-to-back requests SHALL see ack every second cycle.
REQ-010 Writes take effect at the clock edge that asserts wb_ack_o; read data SHALL be valid while wb_ack_o is high.
REQ-011 act[i] = irq_i[i] XOR POLARITY[i]; prev[i] SHALL register act[i] every cycle.
REQ-012 Edge mode (MODE[i]=1): when act[i] & !prev[i], PENDING[i] SHALL set at that clock edge.
REQ-013 Edge mode: PENDING[i] SHALL hold until a PENDING write with bit i = 1 clears it.
REQ-014 Edge mode: if a set and a W1C to the same bit occur in the same cycle, set SHALL win.
REQ-015 Level mode (MODE[i]=0): PENDING[i] SHALL equal prev[i] (registered act); W1C SHALL be ignored.
REQ-016 A MODE or POLARITY write SHALL clear PENDING for every bit whose MODE or POLARITY value changes; prev is not reset by such a write.
REQ-017 irq_o SHALL be a register equal to |(PENDING & ENABLE) from the previous cycle, giving one cycle from PENDING to irq_o.
REQ-018 ID read value:
- bit31 = |(PENDING & ENABLE);
- bits[4:0] = lowest index i with PENDING[i] & ENABLE[i], else 0;
- bits[30:5] = 0.
REQ-019 Disabling a channel SHALL NOT clear its PENDING bit; re-enabling SHALL re-raise irq_o if it is still pending.

Reset
REQ-020 On wb_rst_i high at a clock edge, the following SHALL reset: PENDING=0, MODE=0, POLARITY=0, prev=0, ENABLE=ENABLE_RST[NUM_IRQ-1:0], irq_o=0, wb_ack_o=0, wb_dat_o=0.
REQ-021 Reset asserted mid-transaction SHALL abort it with no ack and no register update; the master must re-issue the request.
REQ-022 Reset SHALL take priority over simultaneous edge detection and writes.

Verification
REQ-023 Edge channel: MODE=0x8, ENABLE=0x8; pulse irq_i[3] for 1 cycle -> PENDING=0x8, irq_o high 1 cycle later, ID=0x80000003; write PENDING=0x8 -> PENDING=0, irq_o low next cycle.
REQ-024 Level channel with polarity: POLARITY=0x2, ENABLE=0x2, irq_i[1]=0 -> RAW=0x2, PENDING=0x2, irq_o=1; W1C of 0x2 -> PENDING unchanged; irq_i[1]=1 -> PENDING=0 after 1 cycle.
REQ-025 Priority: edge on channels 5 and 9 in the same cycle, ENABLE=0x220 -> ID=0x80000005; clear bit 5 -> ID=0x80000009.
REQ-026 Simultaneous set/clear: edge on ch0 in the same cycle as a W1C of 0x1 -> PENDING[0]=1.
REQ-027 Byte lanes and bounds: NUM_IRQ=12; write ENABLE=0xFFFFFFFF with sel=4'b0001 -> ENABLE reads 0x000000FF; write ENABLE=0xFFFFFFFF with sel=4'hF -> ENABLE reads 0x00000FFF; read offset 0x1C -> 0, acked.
REQ-028 Reset mid-access: assert wb_rst_i in the cycle a write request starts -> no ack, all registers at reset values, ENABLE=ENABLE_RST.
